// File: rtl/txc_pkg.sv
// Shared TXC definitions: PHY count, default task length, FSM states and small helpers.
// Define PHY_10 to build for a 10-PHY link instead of the full 32.
package txc_pkg;

`ifdef PHY_10
  localparam int PHY_NUM = 10;
`else
  localparam int PHY_NUM = 32;
`endif

  localparam int TASK_LEN_DEF = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    READ      = 2'd2,
    WAIT_DONE = 2'd3
  } txc_state_e;

  function automatic logic [31:0] phy_valid_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < PHY_NUM; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/txc_rr_arb.sv
// Round-robin PHY picker: lowest eligible index strictly above 'last', wrapping through 0.
module txc_rr_arb
  import txc_pkg::*;
(
  input  logic [31:0] eligible,
  input  logic [4:0]  last,
  output logic [31:0] grant,
  output logic        any
);

  // Scan the 32 positions starting just after the last-served PHY; 'last' itself is visited last.
  always_comb begin
    logic [4:0] idx;
    logic       found;
    grant = 32'd0;
    found = 1'b0;
    idx   = 5'd0;
    for (int k = 1; k <= 32; k++) begin
      idx = last + 5'(k);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    any = found;
  end

endmodule

// File: rtl/txc.sv
// TXC: pulls fixed-length task packets from the task FIFO and streams them to a round-robin PHY.
// Define TXC_TIMEOUT_EN to abort a packet whose PHY never signals done within TO_CYCLES.
module txc
  import txc_pkg::*;
#(
  parameter int TASK_LEN  = TASK_LEN_DEF,
  parameter int TO_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_flush,
  input  logic [31:0] reg_mask,
  input  logic [31:0] reg_busy,
  input  logic [9:0]  tx_fifo_cnt,
  input  logic [31:0] tx_dout,
  output logic        tx_rd_en,
  input  logic [31:0] tx_phy_done,
  output logic        tx_phy_start,
  output logic [31:0] tx_phy_sel,
  output logic        tx_vld,
  output logic [31:0] tx_dat,
  output logic        task_id_vld,
  output logic [31:0] rx_phy_sel,
  output logic [31:0] task_id_h,
  output logic [31:0] task_id_l,
  output logic        tx_timeout
);

  txc_state_e  state_q;
  logic [4:0]  last_q;
  logic [31:0] sel_q;
  logic        start_q;
  logic        rd_en_q;
  logic        vld_q;
  logic [7:0]  cnt_q;
  logic        tid_vld_q;
  logic [31:0] rx_sel_q;
  logic [31:0] h_q;
  logic [31:0] l_q;

  logic [31:0] eligible_d;
  logic [31:0] grant_d;
  logic        any_d;
  logic        start_ok_d;
  logic        done_hit_d;
  logic        to_hit_d;

  assign eligible_d = reg_mask & ~reg_busy & phy_valid_mask();
  assign start_ok_d = (tx_fifo_cnt >= 10'(TASK_LEN)) && any_d;
  assign done_hit_d = (tx_phy_done & sel_q) != 32'd0;

  txc_rr_arb u_arb (
    .eligible (eligible_d),
    .last     (last_q),
    .grant    (grant_d),
    .any      (any_d)
  );

`ifdef TXC_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        to_q;

  // Counts cycles spent waiting for done; cleared whenever we are not waiting.
  always_ff @(posedge clk) begin
    if (rst || reg_flush || state_q != WAIT_DONE) to_cnt_q <= 32'd0;
    else                                          to_cnt_q <= to_cnt_q + 32'd1;
  end

  assign to_hit_d = (state_q == WAIT_DONE) && (to_cnt_q == 32'(TO_CYCLES - 1));

  // A real done in the same cycle retires the packet normally, so no timeout pulse then.
  always_ff @(posedge clk) begin
    if (rst || reg_flush) to_q <= 1'b0;
    else                  to_q <= to_hit_d && !done_hit_d;
  end

  assign tx_timeout = to_q;
`else
  assign to_hit_d   = 1'b0;
  assign tx_timeout = 1'b0;
`endif

  // Main FSM; every strobe is registered and flush overrides any start condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 5'(PHY_NUM - 1);
      sel_q     <= 32'd0;
      start_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      vld_q     <= 1'b0;
      cnt_q     <= 8'd0;
      tid_vld_q <= 1'b0;
      rx_sel_q  <= 32'd0;
    end else if (reg_flush) begin
      state_q   <= IDLE;
      sel_q     <= 32'd0;
      start_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      vld_q     <= 1'b0;
      cnt_q     <= 8'd0;
      tid_vld_q <= 1'b0;
      rx_sel_q  <= 32'd0;
    end else begin
      start_q   <= 1'b0;
      tid_vld_q <= 1'b0;
      rx_sel_q  <= 32'd0;
      vld_q     <= rd_en_q;
      case (state_q)
        IDLE: begin
          if (start_ok_d) begin
            state_q <= START;
            start_q <= 1'b1;
            sel_q   <= grant_d;
          end
        end
        START: begin
          state_q <= READ;
          rd_en_q <= 1'b1;
          cnt_q   <= 8'd0;
        end
        READ: begin
          // Stay one extra cycle after the last read so the final word drains out on tx_vld.
          if (rd_en_q) begin
            if (cnt_q == 8'(TASK_LEN - 1)) rd_en_q <= 1'b0;
            else                           cnt_q   <= cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin
              tid_vld_q <= 1'b1;
              rx_sel_q  <= sel_q;
            end
          end else begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_hit_d) begin
            state_q <= IDLE;
            sel_q   <= 32'd0;
            last_q  <= onehot_to_idx(sel_q);
          end else if (to_hit_d) begin
            state_q <= IDLE;
            sel_q   <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Word 0 is on tx_dout while the counter shows the second read; word 1 follows a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= 32'd0;
      l_q <= 32'd0;
    end else begin
      if (rd_en_q && cnt_q == 8'd1 && state_q == READ && !reg_flush) h_q <= tx_dout;
      if (tid_vld_q) l_q <= tx_dout;
    end
  end

  assign tx_rd_en     = rd_en_q;
  assign tx_phy_start = start_q;
  assign tx_phy_sel   = sel_q;
  assign tx_vld       = vld_q;
  assign tx_dat       = vld_q ? tx_dout : 32'd0;
  assign task_id_vld  = tid_vld_q;
  assign rx_phy_sel   = rx_sel_q;
  assign task_id_h    = h_q;
  assign task_id_l    = tid_vld_q ? tx_dout : l_q;

endmodule

// File: tb/tb_txc.sv
// Self-checking bench for txc: a packet-age model checked every cycle plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_txc;
  import txc_pkg::*;

  localparam int L  = 23;
  localparam int TO = 100;
`ifdef TXC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_flush;
  logic [31:0] reg_mask;
  logic [31:0] reg_busy;
  logic [9:0]  tx_fifo_cnt;
  logic [31:0] tx_dout = 32'd0;
  logic        tx_rd_en;
  logic [31:0] tx_phy_done;
  logic        tx_phy_start;
  logic [31:0] tx_phy_sel;
  logic        tx_vld;
  logic [31:0] tx_dat;
  logic        task_id_vld;
  logic [31:0] rx_phy_sel;
  logic [31:0] task_id_h;
  logic [31:0] task_id_l;
  logic        tx_timeout;

  txc #(.TASK_LEN(L), .TO_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_flush    (reg_flush),
    .reg_mask     (reg_mask),
    .reg_busy     (reg_busy),
    .tx_fifo_cnt  (tx_fifo_cnt),
    .tx_dout      (tx_dout),
    .tx_rd_en     (tx_rd_en),
    .tx_phy_done  (tx_phy_done),
    .tx_phy_start (tx_phy_start),
    .tx_phy_sel   (tx_phy_sel),
    .tx_vld       (tx_vld),
    .tx_dat       (tx_dat),
    .task_id_vld  (task_id_vld),
    .rx_phy_sel   (rx_phy_sel),
    .task_id_h    (task_id_h),
    .task_id_l    (task_id_l),
    .tx_timeout   (tx_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Task FIFO: each accepted read returns the next numbered word one cycle later.
  int f_rp = 0;
  always @(posedge clk) begin
    if (tx_rd_en === 1'b1) begin
      tx_dout <= word(f_rp);
      f_rp    <= f_rp + 1;
    end
  end

  // Model: a packet is described by its age in cycles since tx_phy_start.
  bit          m_act = 1'b0;
  int          m_age = 0;
  logic [31:0] m_sel = 32'd0;
  int          m_pick = 0;
  int          m_last = PHY_NUM - 1;
  int          m_base = 0;
  int          m_rp = 0;
  logic [31:0] m_h = 32'd0;
  logic [31:0] m_l = 32'd0;
  bit          m_to = 1'b0;
  bit          started = 1'b0;
  logic [31:0] t_elig;
  bit          t_found;
  int          t_p;

  initial begin
    forever begin
      @(posedge clk);
      m_to = 1'b0;
      if (m_act && m_age >= 1 && m_age <= L) m_rp = m_rp + 1;
      if (rst) begin
        m_act = 1'b0; m_last = PHY_NUM - 1; m_h = 32'd0; m_l = 32'd0;
      end else if (reg_flush) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        t_elig = reg_mask & ~reg_busy;
        t_found = 1'b0;
        t_p = 0;
        for (int k = 1; k <= PHY_NUM; k++) begin
          if (!t_found && t_elig[(m_last + k) % PHY_NUM]) begin
            t_found = 1'b1;
            t_p = (m_last + k) % PHY_NUM;
          end
        end
        if (int'(tx_fifo_cnt) >= L && t_found) begin
          m_act = 1'b1; m_age = 0; m_pick = t_p;
          m_sel = 32'd1 << t_p; m_base = m_rp;
        end
      end else if (m_age >= L + 2 && (tx_phy_done & m_sel) != 32'd0) begin
        m_act = 1'b0; m_last = m_pick;
      end else if (TO_EN && m_age - (L + 2) == TO - 1) begin
        m_act = 1'b0; m_to = 1'b1;
      end else begin
        m_age = m_age + 1;
        if (m_age == 3) begin
          m_h = word(m_base);
          m_l = word(m_base + 1);
        end
      end
      started = 1'b1;
    end
  end

  bit e_rd, e_vld, e_id;
  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      e_rd  = m_act && m_age >= 1 && m_age <= L;
      e_vld = m_act && m_age >= 2 && m_age <= L + 1;
      e_id  = m_act && m_age == 3;
      check_b("start",   tx_phy_start, m_act && m_age == 0);
      check_w("sel",     tx_phy_sel,   m_act ? m_sel : 32'd0);
      check_b("rd_en",   tx_rd_en,     e_rd);
      check_b("vld",     tx_vld,       e_vld);
      check_w("dat",     tx_dat,       e_vld ? word(m_base + m_age - 2) : 32'd0);
      check_b("id_vld",  task_id_vld,  e_id);
      check_w("rx_sel",  rx_phy_sel,   e_id ? m_sel : 32'd0);
      check_w("id_h",    task_id_h,    m_h);
      check_w("id_l",    task_id_l,    m_l);
      check_b("timeout", tx_timeout,   m_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (tx_phy_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_done(input logic [31:0] v);
    tx_phy_done = v;
    tick();
    tx_phy_done = 32'd0;
  endtask

  bit ok;
  int base;
  int nstart;
  int nto;

  initial begin
    rst = 1'b1; reg_flush = 1'b0; reg_mask = 32'd0; reg_busy = 32'd0;
    tx_fifo_cnt = 10'd0; tx_phy_done = 32'd0;
    repeat (3) tick();
    check_w("rst_sel", tx_phy_sel, 32'd0);
    check_w("rst_h", task_id_h, 32'd0);
    check_w("rst_dat", tx_dat, 32'd0);
    check_b("rst_rd", tx_rd_en, 1'b0);

    // First packet goes to PHY 0, two packets queued.
    rst = 1'b0; reg_mask = 32'h3FF; tx_fifo_cnt = 10'd46;
    wait_start(10, ok);
    check_b("p1_start_seen", ok, 1'b1);
    check_w("p1_sel", tx_phy_sel, 32'h0000_0001);
    repeat (3) tick();
    check_b("p1_id_vld", task_id_vld, 1'b1);
    check_w("p1_h", task_id_h, 32'hC0DE_0000);
    check_w("p1_l", task_id_l, 32'hC0DE_0001);
    repeat (25) tick();
    check_w("p1_reads", 32'(f_rp), 32'd23);
    pulse_done(32'h0000_0008);
    tick();
    check_w("p1_foreign_done", tx_phy_sel, 32'h0000_0001);
    pulse_done(32'h0000_0001);
    wait_start(5, ok);
    check_b("p2_start_seen", ok, 1'b1);
    check_w("p2_sel", tx_phy_sel, 32'h0000_0002);
    tx_fifo_cnt = 10'd0;
    repeat (26) tick();
    pulse_done(32'h0000_0002);
    repeat (2) tick();
    check_w("p2_retired", tx_phy_sel, 32'd0);

    // All PHYs busy, then PHY 5 frees up.
    reg_busy = 32'h3FF; tx_fifo_cnt = 10'd23;
    nstart = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_phy_start === 1'b1) nstart++;
    end
    check_w("busy_no_start", 32'(nstart), 32'd0);
    reg_busy = 32'h3DF;
    wait_start(10, ok);
    check_b("p3_start_seen", ok, 1'b1);
    check_w("p3_sel", tx_phy_sel, 32'h0000_0020);
    tx_fifo_cnt = 10'd0; reg_busy = 32'h3FF;
    repeat (26) tick();
    pulse_done(32'h0000_0020);
    repeat (2) tick();

    // Flush during the 10th read.
    reg_busy = 32'd0; tx_fifo_cnt = 10'd23;
    wait_start(10, ok);
    check_b("p4_start_seen", ok, 1'b1);
    check_w("p4_sel", tx_phy_sel, 32'h0000_0040);
    base = f_rp;
    tx_fifo_cnt = 10'd0;
    repeat (10) tick();
    reg_flush = 1'b1;
    tick();
    reg_flush = 1'b0;
    check_b("flush_rd", tx_rd_en, 1'b0);
    check_w("flush_sel", tx_phy_sel, 32'd0);
    check_w("flush_words", 32'(f_rp - base), 32'd10);

    // Flush beats a simultaneous start condition; pointer is kept.
    tx_fifo_cnt = 10'd23; reg_flush = 1'b1;
    tick();
    reg_flush = 1'b0;
    check_b("flush_wins", tx_phy_start, 1'b0);
    wait_start(5, ok);
    check_b("p5_start_seen", ok, 1'b1);
    check_w("p5_sel", tx_phy_sel, 32'h0000_0040);
    tx_fifo_cnt = 10'd0;
    if (TO_EN) begin
      nto = 0;
      for (int i = 0; i < L + TO + 20; i++) begin
        tick();
        if (tx_timeout === 1'b1) nto++;
      end
      check_w("timeout_pulses", 32'(nto), 32'd1);
      check_w("timeout_sel", tx_phy_sel, 32'd0);
    end else begin
      repeat (26) tick();
      pulse_done(32'h0000_0040);
      repeat (2) tick();
      check_w("p5_retired", tx_phy_sel, 32'd0);
    end
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/txc.md
TXC -- requirements
Module: txc

Interface
REQ-001 Parameter TASK_LEN, default 23, is the number of 32-bit words per task packet; the legal range is 3..255.
REQ-002 Parameter TO_CYCLES, default 65535, is the number of cycles the block waits for tx_phy_done before aborting (used only with TXC_TIMEOUT_EN).
REQ-003 clk  in  1  sole clock; all logic is on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 reg_flush  in  1  synchronous abort; returns the block to IDLE.
REQ-006 reg_mask  in  32  PHY enable; bit i=1 allows PHY i to be selected.
REQ-007 reg_busy  in  32  PHY busy; bit i=1 excludes PHY i from selection.
REQ-008 tx_fifo_cnt  in  10  occupancy of the task FIFO.
REQ-009 tx_dout  in  32  FIFO read data, valid 1 cycle after tx_rd_en.
REQ-010 tx_rd_en  out  1  FIFO read strobe.
REQ-011 tx_phy_done  in  32  per-PHY one-cycle pulse marking the end of serialisation.
REQ-012 tx_phy_start  out  1  one-cycle pulse that opens a packet.
REQ-013 tx_phy_sel  out  32  one-hot PHY select, held from tx_phy_start until the packet retires.
REQ-014 tx_vld / tx_dat  out  1 / 32  word strobe and packet word toward the selected PHY.
REQ-015 task_id_vld  out  1  one-cycle pulse to rxc.
REQ-016 rx_phy_sel  out  32  copy of tx_phy_sel, valid while task_id_vld is high.
REQ-017 task_id_h / task_id_l  out  32 / 32  packet words 0 and 1, held until the next task_id_vld.
REQ-018 tx_timeout  out  1  one-cycle pulse on abort (TXC_TIMEOUT_EN only).

Function
REQ-019 The FSM SHALL have the states IDLE, START, READ, WAIT_DONE.
REQ-020 IDLE: when tx_fifo_cnt >= TASK_LEN and at least one eligible PHY exists, the FSM SHALL go to START; otherwise it SHALL stay in IDLE.
- Eligible PHY i: i < PHY_NUM, reg_mask[i]=1, reg_busy[i]=0.
REQ-021 PHY choice SHALL be round-robin: the lowest eligible index above the last-served PHY, wrapping to 0; the first choice after reset SHALL be PHY 0 if it is eligible.
REQ-022 START (1 cycle): tx_phy_start=1, tx_phy_sel latched one-hot; next state READ.
REQ-023 READ: tx_rd_en SHALL be high for exactly TASK_LEN consecutive cycles, driven by a word counter from 0 to TASK_LEN-1.
REQ-024 Output data timing:
- tx_vld=1 and tx_dat=tx_dout on the cycle after each read.
- If start is at cycle T, reads occur at T+1..T+TASK_LEN and tx_vld at T+2..T+TASK_LEN+1.
REQ-025 Task ID capture:
- Word 0 SHALL be captured into task_id_h and word 1 into task_id_l.
- task_id_vld SHALL pulse with rx_phy_sel=tx_phy_sel on the cycle that word 1 is presented.
REQ-026 After the last tx_vld, the FSM SHALL enter WAIT_DONE. It SHALL return to IDLE on (tx_phy_done & tx_phy_sel)!=0 and update the last-served PHY; done pulses from unselected PHYs SHALL be ignored.
REQ-027 reg_busy and reg_mask changes after START SHALL NOT alter an in-flight packet.
REQ-028 reg_flush in any state SHALL, on the next edge:
- return the FSM to IDLE;
- deassert tx_rd_en, tx_vld, tx_phy_start and task_id_vld;
- clear tx_phy_sel.
A partially read packet SHALL be discarded, and the last-served pointer SHALL be kept.
REQ-029 If reg_flush and IDLE start conditions occur in the same cycle, flush SHALL win.

Reset
REQ-030 On rst the state SHALL be IDLE, the last-served pointer SHALL be PHY_NUM-1, and every output SHALL be 0, including task_id_h, task_id_l and tx_dat.

Configuration
REQ-031 With TXC_TIMEOUT_EN defined:
- A cycle counter SHALL run in WAIT_DONE.
- When it reaches TO_CYCLES, the block SHALL pulse tx_timeout, clear tx_phy_sel, and return to IDLE.
REQ-032 Without TXC_TIMEOUT_EN, the counter SHALL be absent, tx_timeout SHALL be tied to 0, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-033 PHY_NUM and the PHY_10 option SHALL come from the shared alink_define include; TASK_LEN's default SHALL be a named constant there.
REQ-034 The round-robin picker SHALL be one sub-module, txc_rr_arb: inputs eligible[31:0] and last[4:0], outputs grant one-hot and any.

Verification
REQ-035 Reset, then tx_fifo_cnt=23, mask=0x3FF, busy=0 -> start at T with sel=0x001; 23 reads; task_id_vld at T+3 with h=word0, l=word1.
REQ-036 Two packets queued, PHY0 done after the first -> second packet goes to sel=0x002 (round-robin).
REQ-037 mask=0x3FF, busy=0x3FF -> no tx_phy_start; when busy[5] falls -> sel=0x020.
REQ-038 reg_flush at the 10th read -> tx_rd_en low on the next cycle, FSM in IDLE, only 10 words read.
REQ-039 TXC_TIMEOUT_EN, TO_CYCLES=100, no done -> tx_timeout pulse 100 cycles into WAIT_DONE, then IDLE.
REQ-040 tx_phy_done[3] while PHY0 is selected -> ignored; FSM stays in WAIT_DONE.
